serdes_frame: RTL and testbench
===============================

// Module: serdes_frame
// PURPOSE
//   Parametrised serializer/deserializer pair. Frames a DATA_WIDTH word as: start bit, data bits, optional parity bit, stop bits.
//   The serial line can loop back internally or go out on external pins.
//   Successor to the fixed even-parity loopback serdes. Adds odd/none parity, bit order, multi-stop framing,
//   frame-error detection and back-to-back words without reset. Sits between word-level logic and a serial link.
// PARAMETERS
//   DATA_WIDTH   8  word width, 1..32
//   PARITY_MODE  1  0 = none, 1 = even, 2 = odd
//   LSB_FIRST    1  1 = data bit 0 sent first; 0 = MSB first
//   STOP_BITS    1  stop bits per frame, 1..2
// PORTS
//   clk             in   1           system clock, rising edge
//   rst             in   1           asynchronous reset, active-high
//   load            in   1           capture data_in into TX (only honoured while ready_tx=1)
//   data_in         in   DATA_WIDTH  word to transmit
//   enable          in   1           bit strobe: one serial bit advances per clk cycle with enable=1
//   loopback        in   1           1 = RX samples tx_serial; 0 = RX samples rx_serial
//   rx_serial       in   1           external serial input, idle high
//   tx_serial       out  1           registered serial output, idle high
//   data_out        out  DATA_WIDTH  last received word, held until next done
//   done            out  1           one-cycle pulse, frame received
//   parity_error    out  1           parity status of last frame, held until next done
//   frame_error     out  1           any stop bit sampled 0 in last frame, held until next done
//   ready_tx        out  1           TX idle, able to accept load
//   ready_rx        out  1           RX idle, hunting for start bit
// BEHAVIOUR
//   Reset (async): tx_serial=1, data_out=0, done=0, parity_error=0, frame_error=0, ready_tx=1, ready_rx=1. Both FSMs go IDLE. A frame in flight is discarded.
//   Frame length F = 1 + DATA_WIDTH + (PARITY_MODE!=0) + STOP_BITS bits.
//   Parity bit: even -> ^word; odd -> ~^word. Total ones over data+parity is even (mode 1) or odd (mode 2).
//   TX FSM, IDLE -> START -> DATA -> PARITY (skipped if mode 0) -> STOP -> IDLE:
//     - load & ready_tx: word latched; ready_tx<=0 on the next edge. load with ready_tx=0 is ignored.
//     - Strobes count from 0. The first enable cycle after the load cycle is strobe 0. Enable in the load cycle itself does not count.
//     - Strobe k registers frame bit k onto tx_serial, k = 0..F-1.
//     - Strobe F: tx_serial stays 1 and ready_tx<=1. A new load is accepted in the next cycle.
//     - enable=0 freezes TX. Cycles without enable are legal anywhere.
//   RX FSM, IDLE -> DATA -> PARITY (skipped if mode 0) -> STOP -> IDLE:
//     - Samples the selected line only on enable cycles.
//     - In IDLE, sampling 0 detects start; ready_rx<=0.
//     - The next F-1 enabled samples are data, parity and stop bits. Data bits are placed per LSB_FIRST.
//     - Sample of the last stop bit: on that edge, data_out, parity_error and frame_error update, done=1 for exactly one cycle, ready_rx<=1.
//     - parity_error is always 0 when PARITY_MODE=0.
//     - frame_error does not suppress done. data_out updates regardless of errors.
//   Loopback timing: RX lags TX by one strobe. With enable held high, done is asserted on the edge of TX strobe F.
//     - ready_tx and ready_rx rise on that same edge.
//   Back-to-back: load in the cycle after done. The next frame is received correctly with no reset.
//   Idle line at 1: RX stays IDLE, no done.
//   Changing loopback while ready_rx=0: data is undefined, but RX returns to IDLE within F strobes with no lockup.
//   Reset asserted mid-frame: tx_serial=1 immediately. No done is produced for the aborted frame.
// TESTING
//   1) Default params, loopback=1, enable held high, sweep data_in 0..255 without reset between words.
//      -> data_out==data_in each word; parity_error=0; frame_error=0; done exactly once per word.
//   2) Load 8'hA5, enable high -> done on strobe F=11; tx_serial strobes 0..10 = 0,1,0,1,0,0,1,0,1,0,1 (LSB first).
//   3) loopback=0, bench drives a frame of 8'h3C with parity bit 1 (wrong for even)
//      -> data_out=8'h3C, parity_error=1, frame_error=0.
//   4) loopback=0, frame of 8'h81 with stop bit 0 -> done pulses, frame_error=1.
//      Next valid frame 8'h7E -> frame_error=0, data_out=8'h7E.
//   5) Enable toggled 1/0 every cycle during 8'h5A -> same data_out as enable held high; done after 2F strobes' worth of clocks.
//   6) Assert rst at strobe 4 of 8'hFF -> outputs at reset values, no done.
//      Then 8'h12 -> data_out=8'h12, errors 0.
//   Rerun 1) with PARITY_MODE=2, LSB_FIRST=0, STOP_BITS=2, DATA_WIDTH=12 (random 200 words).

Source files
------------

// File: rtl/serdes_frame.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serdes_frame
//   Parametrised serializer/deserializer pair. A DATA_WIDTH word is framed as
//   start bit (0), data bits (order set by LSB_FIRST), optional parity bit,
//   then STOP_BITS stop bits (1). One serial bit moves per enabled clock.
//   The receiver samples either the local tx_serial (loopback) or rx_serial.
//
// Parameters
//   DATA_WIDTH  word width, 1..32
//   PARITY_MODE 0 = none, 1 = even, 2 = odd
//   LSB_FIRST   1 = data bit 0 first, 0 = MSB first
//   STOP_BITS   stop bits per frame, 1..2
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-high
//   load         in   capture data_in into TX while ready_tx=1
//   data_in      in   word to transmit
//   enable       in   bit strobe, one serial bit per enabled cycle
//   loopback     in   1 = RX samples tx_serial, 0 = RX samples rx_serial
//   rx_serial    in   external serial input, idle high
//   tx_serial    out  registered serial output, idle high
//   data_out     out  last received word
//   done         out  one-cycle pulse when a frame has been received
//   parity_error out  parity status of last frame
//   frame_error  out  a stop bit of the last frame was sampled 0
//   ready_tx     out  TX idle, load accepted
//   ready_rx     out  RX idle, hunting for a start bit
// -----------------------------------------------------------------------------
module serdes_frame #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int LSB_FIRST   = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enable,
  input  logic                  loopback,
  input  logic                  rx_serial,
  output logic                  tx_serial,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  ready_tx,
  output logic                  ready_rx
);

  localparam int             IW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0]  LAST_IDX   = IW'(DATA_WIDTH - 1);
  localparam logic [1:0]     LAST_STOP  = 2'(STOP_BITS - 1);
  localparam logic [1:0]     STOP_COUNT = 2'(STOP_BITS);
  localparam bit             HAS_PARITY = (PARITY_MODE != 0);

  // Parity bit that makes the data+parity ones count even (mode 1) or odd (mode 2).
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] w);
    return (PARITY_MODE == 2) ? ~^w : ^w;
  endfunction

  // Map the n-th transmitted data bit to its position in the word.
  function automatic logic [IW-1:0] bit_index(input logic [IW-1:0] n);
    return (LSB_FIRST != 0) ? n : (LAST_IDX - n);
  endfunction

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  tx_state_t             tx_state_q;
  logic [DATA_WIDTH-1:0] tx_word_q;
  logic [IW-1:0]         tx_cnt_q;
  logic [1:0]            tx_stop_q;
  logic                  tx_serial_q;
  logic                  ready_tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_word_q   <= '0;
      tx_cnt_q    <= '0;
      tx_stop_q   <= '0;
      tx_serial_q <= 1'b1;
      ready_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          // Enable in the load cycle is deliberately ignored: the first
          // strobe is the first enabled cycle after the word is latched.
          if (load && ready_tx_q) begin
            tx_word_q  <= data_in;
            ready_tx_q <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (enable) begin
            tx_serial_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_state_q  <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (enable) begin
            tx_serial_q <= tx_word_q[bit_index(tx_cnt_q)];
            if (tx_cnt_q == LAST_IDX) begin
              tx_stop_q <= '0;
              if (HAS_PARITY) tx_state_q <= TX_PARITY;
              else            tx_state_q <= TX_STOP;
            end else begin
              tx_cnt_q <= tx_cnt_q + IW'(1);
            end
          end
        end
        TX_PARITY: begin
          if (enable) begin
            tx_serial_q <= parity_of(tx_word_q);
            tx_stop_q   <= '0;
            tx_state_q  <= TX_STOP;
          end
        end
        TX_STOP: begin
          // STOP_BITS strobes drive the stop bits; one extra strobe marks
          // the end of the frame so the receiver (one strobe behind in
          // loopback) finishes on the same edge that TX frees up.
          if (enable) begin
            if (tx_stop_q == STOP_COUNT) begin
              ready_tx_q <= 1'b1;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_serial_q <= 1'b1;
              tx_stop_q   <= tx_stop_q + 2'd1;
            end
          end
        end
        default: begin
          tx_serial_q <= 1'b1;
          ready_tx_q  <= 1'b1;
          tx_state_q  <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  rx_state_t             rx_state_q;
  logic [DATA_WIDTH-1:0] rx_word_q;
  logic [IW-1:0]         rx_cnt_q;
  logic [1:0]            rx_stop_q;
  logic                  rx_par_q;
  logic                  rx_stop_bad_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  done_q;
  logic                  parity_error_q;
  logic                  frame_error_q;
  logic                  ready_rx_q;
  logic                  rx_line_d;

  // Loopback taps the registered TX output, which makes RX lag TX by one strobe.
  assign rx_line_d = loopback ? tx_serial_q : rx_serial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q     <= RX_IDLE;
      rx_word_q      <= '0;
      rx_cnt_q       <= '0;
      rx_stop_q      <= '0;
      rx_par_q       <= 1'b0;
      rx_stop_bad_q  <= 1'b0;
      data_out_q     <= '0;
      done_q         <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      ready_rx_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (enable) begin
        case (rx_state_q)
          RX_IDLE: begin
            if (!rx_line_d) begin
              ready_rx_q    <= 1'b0;
              rx_cnt_q      <= '0;
              rx_stop_bad_q <= 1'b0;
              rx_state_q    <= RX_DATA;
            end
          end
          RX_DATA: begin
            rx_word_q[bit_index(rx_cnt_q)] <= rx_line_d;
            if (rx_cnt_q == LAST_IDX) begin
              rx_stop_q <= '0;
              if (HAS_PARITY) rx_state_q <= RX_PARITY;
              else            rx_state_q <= RX_STOP;
            end else begin
              rx_cnt_q <= rx_cnt_q + IW'(1);
            end
          end
          RX_PARITY: begin
            rx_par_q   <= rx_line_d;
            rx_stop_q  <= '0;
            rx_state_q <= RX_STOP;
          end
          RX_STOP: begin
            // Frame ends on the last stop sample regardless of its value, so
            // a corrupted line can never hold RX away from IDLE.
            if (rx_stop_q == LAST_STOP) begin
              data_out_q     <= rx_word_q;
              parity_error_q <= HAS_PARITY && (rx_par_q != parity_of(rx_word_q));
              frame_error_q  <= rx_stop_bad_q | ~rx_line_d;
              done_q         <= 1'b1;
              ready_rx_q     <= 1'b1;
              rx_state_q     <= RX_IDLE;
            end else begin
              rx_stop_bad_q <= rx_stop_bad_q | ~rx_line_d;
              rx_stop_q     <= rx_stop_q + 2'd1;
            end
          end
          default: begin
            ready_rx_q <= 1'b1;
            rx_state_q <= RX_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_serial    = tx_serial_q;
  assign ready_tx     = ready_tx_q;
  assign data_out     = data_out_q;
  assign done         = done_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign ready_rx     = ready_rx_q;

endmodule

// File: tb/tb_serdes_frame.sv
`timescale 1ns/1ps
// Bench for serdes_frame: one default instance (8 bit, even, LSB first, 1 stop)
// and one alternate instance (12 bit, odd, MSB first, 2 stops). Expected
// frames and results come from a bit-list model of the framing rules.
module tb_serdes_frame;

  logic clk;
  logic rst;

  logic        load0, en0, lb0, rxs0;
  logic [7:0]  din0;
  logic        tx0, done0, perr0, ferr0, rdytx0, rdyrx0;
  logic [7:0]  dout0;

  logic        load1, en1, lb1, rxs1;
  logic [11:0] din1;
  logic        tx1, done1, perr1, ferr1, rdytx1, rdyrx1;
  logic [11:0] dout1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] last_cap;

  serdes_frame dut0 (
    .clk(clk), .rst(rst), .load(load0), .data_in(din0), .enable(en0),
    .loopback(lb0), .rx_serial(rxs0), .tx_serial(tx0), .data_out(dout0),
    .done(done0), .parity_error(perr0), .frame_error(ferr0),
    .ready_tx(rdytx0), .ready_rx(rdyrx0)
  );

  serdes_frame #(.DATA_WIDTH(12), .PARITY_MODE(2), .LSB_FIRST(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .data_in(din1), .enable(en1),
    .loopback(lb1), .rx_serial(rxs1), .tx_serial(tx1), .data_out(dout1),
    .done(done1), .parity_error(perr1), .frame_error(ferr1),
    .ready_tx(rdytx1), .ready_rx(rdyrx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance parameters as seen by the model.
  function automatic int p_w(input int sel);   return sel ? 12 : 8; endfunction
  function automatic int p_pm(input int sel);  return sel ? 2 : 1;  endfunction
  function automatic int p_lsb(input int sel); return sel ? 0 : 1;  endfunction
  function automatic int p_sb(input int sel);  return sel ? 2 : 1;  endfunction

  // Frame as a bit list: bit k of the result is serial bit k.
  function automatic logic [63:0] frame_model(input logic [31:0] word, input int sel,
                                               output int flen);
    logic [63:0] v;
    logic [31:0] t;
    int w, ones, k;
    w = p_w(sel);
    v = '0;
    ones = 0;
    k = 1;                                   // bit 0 is the start bit (0)
    for (int i = 0; i < w; i++) begin
      t = word >> ((p_lsb(sel) != 0) ? i : (w - 1 - i));
      if (t[0]) begin
        v = v | (64'd1 << k);
        ones++;
      end
      k++;
    end
    if (p_pm(sel) != 0) begin
      if ((p_pm(sel) == 1 && (ones % 2) == 1) || (p_pm(sel) == 2 && (ones % 2) == 0))
        v = v | (64'd1 << k);
      k++;
    end
    for (int s = 0; s < p_sb(sel); s++) begin
      v = v | (64'd1 << k);
      k++;
    end
    flen = k;
    return v;
  endfunction

  function automatic logic get_done(input int sel);  return sel ? done1 : done0;   endfunction
  function automatic logic get_tx(input int sel);    return sel ? tx1 : tx0;       endfunction
  function automatic logic get_perr(input int sel);  return sel ? perr1 : perr0;   endfunction
  function automatic logic get_ferr(input int sel);  return sel ? ferr1 : ferr0;   endfunction
  function automatic logic get_rdytx(input int sel); return sel ? rdytx1 : rdytx0; endfunction
  function automatic logic get_rdyrx(input int sel); return sel ? rdyrx1 : rdyrx0; endfunction
  function automatic logic [31:0] get_dout(input int sel);
    return sel ? 32'(dout1) : 32'(dout0);
  endfunction

  task automatic set_in(input int sel, input logic ld, input logic [31:0] dat, input logic en);
    if (sel != 0) begin
      load1 = ld; din1 = dat[11:0]; en1 = en;
    end else begin
      load0 = ld; din0 = dat[7:0]; en0 = en;
    end
  endtask

  task automatic set_rxs(input int sel, input logic b);
    if (sel != 0) rxs1 = b; else rxs0 = b;
  endtask

  // Send one word (loopback must already be on) and check what RX delivers.
  // toggle=1 alternates enable starting with 0 in the load cycle.
  task automatic run_word(input int sel, input logic [31:0] word, input bit toggle);
    logic [63:0] ev;
    logic [63:0] cap;
    int flen, lat, exp_lat;
    ev = frame_model(word, sel, flen);
    for (int t = 0; t < 200 && !get_rdytx(sel); t++) tick();
    check("ready_tx_before_load", 64'(get_rdytx(sel)), 64'd1);
    set_in(sel, 1'b1, word, toggle ? 1'b0 : 1'b1);
    tick();
    set_in(sel, 1'b0, word, toggle ? 1'b0 : 1'b1);
    check("ready_tx_busy", 64'(get_rdytx(sel)), 64'd0);
    check("done_pulse_width", 64'(get_done(sel)), 64'd0);
    cap = '0;
    lat = -1;
    for (int n = 1; n <= 4 * flen + 10; n++) begin
      set_in(sel, 1'b0, word, toggle ? ((n % 2) == 1) : 1'b1);
      tick();
      if (!toggle && n <= flen && get_tx(sel)) cap = cap | (64'd1 << (n - 1));
      if (get_done(sel)) begin
        lat = n;
        break;
      end
    end
    exp_lat = toggle ? (2 * flen + 1) : (flen + 1);
    check("done_latency", 64'(lat), 64'(exp_lat));
    check("data_out", 64'(get_dout(sel)), 64'(word));
    check("parity_error", 64'(get_perr(sel)), 64'd0);
    check("frame_error", 64'(get_ferr(sel)), 64'd0);
    check("ready_both_at_done", {62'd0, get_rdytx(sel), get_rdyrx(sel)}, 64'd3);
    if (!toggle) check("tx_bits", cap, ev);
    last_cap = cap;
    $display("word sel=%0d data=%0h latency=%0d data_out=%0h", sel, word, lat, get_dout(sel));
  endtask

  // Drive a frame on rx_serial with optional parity flip or one stop bit forced 0.
  task automatic rx_frame(input int sel, input logic [31:0] word, input bit flip, input int stop_zero);
    logic [63:0] v;
    logic [63:0] t;
    int flen, early, hp;
    v = frame_model(word, sel, flen);
    hp = (p_pm(sel) != 0) ? 1 : 0;
    if (flip) v = v ^ (64'd1 << (1 + p_w(sel)));
    if (stop_zero >= 0) v = v & ~(64'd1 << (1 + p_w(sel) + hp + stop_zero));
    set_in(sel, 1'b0, word, 1'b1);
    set_rxs(sel, 1'b1);
    tick();
    tick();
    early = 0;
    for (int k = 0; k < flen; k++) begin
      t = v >> k;
      set_rxs(sel, t[0]);
      tick();
      if (k < flen - 1 && get_done(sel)) early++;
    end
    check("rx_no_early_done", 64'(early), 64'd0);
    check("rx_done", 64'(get_done(sel)), 64'd1);
    check("rx_data_out", 64'(get_dout(sel)), 64'(word));
    check("rx_parity_error", 64'(get_perr(sel)), 64'(flip));
    check("rx_frame_error", 64'(get_ferr(sel)), 64'(stop_zero >= 0));
    set_rxs(sel, 1'b1);
    tick();
    check("rx_done_one_cycle", 64'(get_done(sel)), 64'd0);
    $display("rxframe sel=%0d data=%0h flip=%0d stop_zero=%0d data_out=%0h perr=%0d ferr=%0d",
             sel, word, flip, stop_zero, get_dout(sel), get_perr(sel), get_ferr(sel));
  endtask

  initial begin
    logic [63:0] lit;
    int cnt;
    rst = 1'b1;
    load0 = 0; en0 = 0; lb0 = 1; rxs0 = 1; din0 = '0;
    load1 = 0; en1 = 0; lb1 = 0; rxs1 = 1; din1 = '0;
    tick(); tick(); tick();
    check("reset_dut0", {tx0, dout0, done0, perr0, ferr0, rdytx0, rdyrx0},
          {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    check("reset_dut1", {tx1, dout1, done1, perr1, ferr1, rdytx1, rdyrx1},
          {1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    rst = 1'b0;

    // Idle line held high: no start detected, no done.
    lb0 = 1'b0; en0 = 1'b1; rxs0 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done0) cnt++;
    end
    check("idle_no_done", 64'(cnt), 64'd0);
    check("idle_ready_rx", 64'(rdyrx0), 64'd1);

    // A5 with enable held high, serial bits against the literal sequence.
    lb0 = 1'b1;
    run_word(0, 32'hA5, 1'b0);
    lit = 64'b10101001010;
    check("a5_tx_sequence", last_cap, lit);

    // Sweep all bytes back to back.
    for (int w = 0; w < 256; w++) run_word(0, 32'(w), 1'b0);

    // Enable toggling every cycle.
    run_word(0, 32'h5A, 1'b1);

    // External line: parity error, frame error, then a clean frame.
    lb0 = 1'b0;
    rx_frame(0, 32'h3C, 1'b1, -1);
    rx_frame(0, 32'h81, 1'b0, 0);
    rx_frame(0, 32'h7E, 1'b0, -1);

    // Reset in the middle of a frame.
    lb0 = 1'b1;
    set_in(0, 1'b1, 32'hFF, 1'b1);
    tick();
    set_in(0, 1'b0, 32'hFF, 1'b1);
    for (int i = 0; i < 5; i++) tick();       // strobes 0..4
    rst = 1'b1;
    #1;
    check("midframe_reset_vals", {tx0, dout0, done0, perr0, ferr0, rdytx0, rdyrx0},
          {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done0) cnt++;
    end
    check("aborted_no_done", 64'(cnt), 64'd0);
    run_word(0, 32'h12, 1'b0);
    en0 = 1'b0;

    // Alternate instance: external error frames, then random loopback words.
    lb1 = 1'b0;
    rx_frame(1, 32'hABC, 1'b1, -1);
    rx_frame(1, 32'h5A3, 1'b0, 1);
    rx_frame(1, 32'h801, 1'b0, -1);
    lb1 = 1'b1;
    for (int i = 0; i < 200; i++) run_word(1, 32'($urandom_range(0, 4095)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
